multicycle_sequencer: RTL and testbench

Parametrised successor to the two-state FETCH/DEMW control unit. It owns the RV32I multicycle state machine and handshakes with variable-latency memory through request/ready pairs. A bus timeout raises an access fault, and a TRAP state redirects the PC to the trap vector. Decode of ir_i is delegated to a combinational sub-module; this block gates the decoded strobes by state.

---
 rtl/multicycle_sequencer_pkg.sv | 67 ++++++
 rtl/multicycle_sequencer_if.sv | 21 ++
 rtl/multicycle_sequencer_instr_decoder.sv | 87 ++++++++
 rtl/multicycle_sequencer.sv | 137 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the RV32I multicycle sequencer: state encoding, datapath
// select enums, the decoder bundle and mcause codes.
package multicycle_sequencer_pkg;

  typedef enum logic [1:0] {FETCH, EXECUTE, MEM, TRAP} seq_state_t;

  typedef enum logic {MEM_RD_ADDR_SEL_PC, MEM_RD_ADDR_SEL_ALU_OUT} mem_rd_addr_sel_t;

  typedef enum logic [2:0] {
    MEM_ACCESS_SIZE_BYTE, MEM_ACCESS_SIZE_HALF, MEM_ACCESS_SIZE_WORD,
    MEM_ACCESS_SIZE_BYTE_U, MEM_ACCESS_SIZE_HALF_U
  } mem_access_size_t;

  typedef enum logic [1:0] {
    NEXT_PC_SEL_PC_PLUS_4, NEXT_PC_SEL_ALU_OUT, NEXT_PC_SEL_COND_BRANCH, NEXT_PC_SEL_TRAP_VECTOR
  } next_pc_sel_t;

  typedef enum logic [1:0] {
    REGFILE_IN_SEL_ALU_OUT, REGFILE_IN_SEL_MEM_RD, REGFILE_IN_SEL_PC_PLUS_4, REGFILE_IN_SEL_CSR_RD
  } regfile_in_sel_t;

  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND
  } alu_op_t;

  typedef enum logic [1:0] {ALU_IN1_SEL_RS1, ALU_IN1_SEL_PC, ALU_IN1_SEL_ZERO} alu_in1_sel_t;
  typedef enum logic {ALU_IN2_SEL_RS2, ALU_IN2_SEL_IMM} alu_in2_sel_t;

  typedef enum logic [2:0] {
    COMPARE_UNIT_OP_EQ, COMPARE_UNIT_OP_NE, COMPARE_UNIT_OP_LT,
    COMPARE_UNIT_OP_GE, COMPARE_UNIT_OP_LTU, COMPARE_UNIT_OP_GEU
  } compare_unit_op_t;

  localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;

  typedef struct packed {
    next_pc_sel_t     next_pc_sel;
    regfile_in_sel_t  regfile_in_sel;
    alu_op_t          alu_op;
    alu_in1_sel_t     alu_in1_sel;
    alu_in2_sel_t     alu_in2_sel;
    compare_unit_op_t compare_unit_op;
    mem_access_size_t rd_size;
    mem_access_size_t wr_size;
    logic rf_we, csr_we, mem_we, is_load, is_store, illegal, ecall, ebreak;
  } dec_t;

  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'd1:    return ALU_OP_SLL;
      3'd2:    return ALU_OP_SLT;
      3'd3:    return ALU_OP_SLTU;
      3'd4:    return ALU_OP_XOR;
      3'd5:    return alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'd6:    return ALU_OP_OR;
      default: return ALU_OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the sequencer (master) and memory (slave).
interface multicycle_sequencer_if;
  import multicycle_sequencer_pkg::*;

  logic             mem_rd_req_o;
  logic             mem_wr_req_o;
  mem_rd_addr_sel_t mem_rd_addr_sel_o;
  mem_access_size_t mem_rd_size_o;
  mem_access_size_t mem_wr_size_o;
  logic             mem_rd_ready_i;
  logic             mem_wr_ready_i;

  modport master (
    output mem_rd_req_o, mem_wr_req_o, mem_rd_addr_sel_o, mem_rd_size_o, mem_wr_size_o,
    input  mem_rd_ready_i, mem_wr_ready_i
  );
  modport slave (
    input  mem_rd_req_o, mem_wr_req_o, mem_rd_addr_sel_o, mem_rd_size_o, mem_wr_size_o,
    output mem_rd_ready_i, mem_wr_ready_i
  );
endinterface

// File: rtl/multicycle_sequencer_instr_decoder.sv
// Combinational RV32I decoder: datapath selects plus raw write intents.
// Any illegal encoding has every side effect cleared so it can retire as a NOP.
module instr_decoder
  import multicycle_sequencer_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = ir_i[6:0];
  assign f3  = ir_i[14:12];
  assign f7  = ir_i[31:25];

  always_comb begin
    dec_o             = '0;
    dec_o.alu_in2_sel = ALU_IN2_SEL_IMM;
    dec_o.rd_size     = MEM_ACCESS_SIZE_WORD;
    dec_o.wr_size     = MEM_ACCESS_SIZE_WORD;
    case (opc)
      7'b0110111: begin dec_o.rf_we = 1'b1; dec_o.alu_in1_sel = ALU_IN1_SEL_ZERO; end
      7'b0010111: begin dec_o.rf_we = 1'b1; dec_o.alu_in1_sel = ALU_IN1_SEL_PC; end
      7'b1101111, 7'b1100111: begin
        dec_o.illegal        = (opc == 7'b1100111) && (f3 != 3'd0);
        dec_o.rf_we          = 1'b1;
        dec_o.alu_in1_sel    = (opc == 7'b1101111) ? ALU_IN1_SEL_PC : ALU_IN1_SEL_RS1;
        dec_o.regfile_in_sel = REGFILE_IN_SEL_PC_PLUS_4;
        dec_o.next_pc_sel    = NEXT_PC_SEL_ALU_OUT;
      end
      7'b1100011: begin
        dec_o.illegal         = (f3 == 3'd2) || (f3 == 3'd3);
        dec_o.alu_in1_sel     = ALU_IN1_SEL_PC;
        dec_o.next_pc_sel     = NEXT_PC_SEL_COND_BRANCH;
        dec_o.compare_unit_op = compare_unit_op_t'(f3[2] ? f3 - 3'd2 : f3);
      end
      7'b0000011: begin
        dec_o.illegal        = (f3 == 3'd3) || (f3 > 3'd5);
        dec_o.is_load        = 1'b1;
        dec_o.rf_we          = 1'b1;
        dec_o.regfile_in_sel = REGFILE_IN_SEL_MEM_RD;
        dec_o.rd_size        = f3[2] ? (f3[0] ? MEM_ACCESS_SIZE_HALF_U : MEM_ACCESS_SIZE_BYTE_U)
                                     : mem_access_size_t'({1'b0, f3[1:0]});
      end
      7'b0100011: begin
        dec_o.illegal  = f3 > 3'd2;
        dec_o.is_store = 1'b1;
        dec_o.mem_we   = 1'b1;
        dec_o.wr_size  = mem_access_size_t'({1'b0, f3[1:0]});
      end
      7'b0010011: begin
        dec_o.illegal = ((f3 == 3'd1) && (f7 != 7'd0)) ||
                        ((f3 == 3'd5) && ((f7 & 7'b1011111) != 7'd0));
        dec_o.rf_we   = 1'b1;
        dec_o.alu_op  = alu_op_from_f3(f3, (f3 == 3'd5) && f7[5]);
      end
      7'b0110011: begin
        dec_o.illegal     = ((f7 & 7'b1011111) != 7'd0) || (f7[5] && (f3 != 3'd0) && (f3 != 3'd5));
        dec_o.rf_we       = 1'b1;
        dec_o.alu_in2_sel = ALU_IN2_SEL_RS2;
        dec_o.alu_op      = alu_op_from_f3(f3, f7[5]);
      end
      7'b0001111: dec_o.illegal = f3 > 3'd1;
      7'b1110011: begin
        if (f3 == 3'd0) begin
          dec_o.ecall   = ir_i == 32'h0000_0073;
          dec_o.ebreak  = ir_i == 32'h0010_0073;
          dec_o.illegal = !(dec_o.ecall || dec_o.ebreak);
        end else if (f3 == 3'd4) begin
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.rf_we          = 1'b1;
          dec_o.csr_we         = 1'b1;
          dec_o.regfile_in_sel = REGFILE_IN_SEL_CSR_RD;
        end
      end
      default: dec_o.illegal = 1'b1;
    endcase
    if (dec_o.illegal) begin
      dec_o.rf_we       = 1'b0;
      dec_o.csr_we      = 1'b0;
      dec_o.mem_we      = 1'b0;
      dec_o.is_load     = 1'b0;
      dec_o.is_store    = 1'b0;
      dec_o.next_pc_sel = NEXT_PC_SEL_PC_PLUS_4;
    end
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// RV32I multicycle FETCH/EXECUTE/MEM/TRAP sequencer with variable-latency
// memory handshake, bus timeout faults and state-gated decoder strobes.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          TRAP_EN     = 1'b1
)(
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [31:0]              ir_i,
  multicycle_sequencer_if.master   mem,
  output logic                     pc_we_o,
  output logic                     ir_we_o,
  output logic                     regfile_we_o,
  output logic                     csr_we_o,
  output next_pc_sel_t             next_pc_sel_o,
  output regfile_in_sel_t          regfile_in_sel_o,
  output alu_op_t                  alu_op_o,
  output alu_in1_sel_t             alu_in1_sel_o,
  output alu_in2_sel_t             alu_in2_sel_o,
  output compare_unit_op_t         compare_unit_op_o,
  output logic                     trap_o,
  output logic [3:0]               trap_cause_o,
  output logic                     instret_o
);
  localparam int unsigned COUNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [COUNT_W-1:0] LAST_WAIT = COUNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  seq_state_t         state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         cause_q, cause_d;
  logic               expired, mem_ready;
  dec_t               dec;

  instr_decoder u_dec (.ir_i(ir_i), .dec_o(dec));

  assign regfile_in_sel_o  = dec.regfile_in_sel;
  assign alu_op_o          = dec.alu_op;
  assign alu_in1_sel_o     = dec.alu_in1_sel;
  assign alu_in2_sel_o     = dec.alu_in2_sel;
  assign compare_unit_op_o = dec.compare_unit_op;
  assign mem.mem_rd_size_o = dec.rd_size;
  assign mem.mem_wr_size_o = dec.wr_size;
  assign trap_cause_o      = cause_q;

  // Expiry only matters when ready is still low; ready in that cycle wins.
  assign expired = (MEM_TIMEOUT > 0) && TRAP_EN && (cnt_q == LAST_WAIT);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    cause_d               = cause_q;
    mem_ready             = 1'b0;
    mem.mem_rd_req_o      = 1'b0;
    mem.mem_wr_req_o      = 1'b0;
    mem.mem_rd_addr_sel_o = MEM_RD_ADDR_SEL_PC;
    pc_we_o               = 1'b0;
    ir_we_o               = 1'b0;
    regfile_we_o          = 1'b0;
    csr_we_o              = 1'b0;
    trap_o                = 1'b0;
    instret_o             = 1'b0;
    next_pc_sel_o         = dec.next_pc_sel;
    unique case (state_q)
      FETCH: begin
        mem.mem_rd_req_o = 1'b1;
        if (mem.mem_rd_ready_i) begin
          ir_we_o = 1'b1;
          state_d = EXECUTE;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_FETCH_FAULT;
        end
      end
      EXECUTE: begin
        if (TRAP_EN && (dec.illegal || dec.ecall || dec.ebreak)) begin
          state_d = TRAP;
          cause_d = dec.illegal ? CAUSE_ILLEGAL : (dec.ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT);
        end else if (dec.is_load || dec.is_store) begin
          state_d = MEM;
        end else begin
          pc_we_o      = 1'b1;
          regfile_we_o = dec.rf_we;
          csr_we_o     = dec.csr_we;
          instret_o    = 1'b1;
          state_d      = FETCH;
        end
      end
      MEM: begin
        mem.mem_rd_req_o = dec.is_load;
        mem.mem_wr_req_o = dec.mem_we;
        if (dec.is_load) mem.mem_rd_addr_sel_o = MEM_RD_ADDR_SEL_ALU_OUT;
        mem_ready = dec.is_load ? mem.mem_rd_ready_i : mem.mem_wr_ready_i;
        if (mem_ready) begin
          pc_we_o      = 1'b1;
          regfile_we_o = dec.is_load;
          instret_o    = 1'b1;
          state_d      = FETCH;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = dec.is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
        end
      end
      TRAP: begin
        pc_we_o       = 1'b1;
        next_pc_sel_o = NEXT_PC_SEL_TRAP_VECTOR;
        trap_o        = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + COUNT_W'(1);
    // Reset drops every request and strobe in the same cycle, not one edge later.
    if (!reset_ni) begin
      mem.mem_rd_req_o = 1'b0;
      mem.mem_wr_req_o = 1'b0;
      pc_we_o          = 1'b0;
      ir_we_o          = 1'b0;
      regfile_we_o     = 1'b0;
      csr_we_o         = 1'b0;
      trap_o           = 1'b0;
      instret_o        = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: main DUT with trapping on, second DUT with TRAP_EN=0.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic [31:0] ir = 32'h0;
  int vecs = 0, errs = 0;

  multicycle_sequencer_if mif();
  multicycle_sequencer_if mif2();

  logic pc_we, ir_we, rf_we, csr_we, trap, instret;
  logic [3:0] cause;
  next_pc_sel_t npc; regfile_in_sel_t rfin; alu_op_t aop;
  alu_in1_sel_t a1; alu_in2_sel_t a2; compare_unit_op_t cop;

  logic pc_we2, ir_we2, rf_we2, csr_we2, trap2, instret2;
  logic [3:0] cause2;
  next_pc_sel_t npc2; regfile_in_sel_t rfin2; alu_op_t aop2;
  alu_in1_sel_t a12; alu_in2_sel_t a22; compare_unit_op_t cop2;

  // {rd_req, wr_req, ir_we, pc_we, rf_we, csr_we, instret, trap}
  logic [7:0] strb, strb2;
  assign strb  = {mif.mem_rd_req_o, mif.mem_wr_req_o, ir_we, pc_we, rf_we, csr_we, instret, trap};
  assign strb2 = {mif2.mem_rd_req_o, mif2.mem_wr_req_o, ir_we2, pc_we2, rf_we2, csr_we2, instret2, trap2};

  multicycle_sequencer #(.MEM_TIMEOUT(16), .TRAP_EN(1'b1)) dut (
    .clk_i(clk), .reset_ni(rst_n), .ir_i(ir), .mem(mif),
    .pc_we_o(pc_we), .ir_we_o(ir_we), .regfile_we_o(rf_we), .csr_we_o(csr_we),
    .next_pc_sel_o(npc), .regfile_in_sel_o(rfin), .alu_op_o(aop), .alu_in1_sel_o(a1),
    .alu_in2_sel_o(a2), .compare_unit_op_o(cop), .trap_o(trap), .trap_cause_o(cause),
    .instret_o(instret));

  multicycle_sequencer #(.MEM_TIMEOUT(4), .TRAP_EN(1'b0)) dut2 (
    .clk_i(clk), .reset_ni(rst2_n), .ir_i(ir), .mem(mif2),
    .pc_we_o(pc_we2), .ir_we_o(ir_we2), .regfile_we_o(rf_we2), .csr_we_o(csr_we2),
    .next_pc_sel_o(npc2), .regfile_in_sel_o(rfin2), .alu_op_o(aop2), .alu_in1_sel_o(a12),
    .alu_in2_sel_o(a22), .compare_unit_op_o(cop2), .trap_o(trap2), .trap_cause_o(cause2),
    .instret_o(instret2));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mif.mem_rd_ready_i = 1'b1; mif.mem_wr_ready_i = 1'b0;
    #1; vecs++;
    if (strb !== 8'h00) begin errs++; $display("FAIL reset_comb got %b want %b", strb, 8'h00); end
    tick; tick; vecs++;
    if ({strb, cause} !== 12'h000) begin errs++; $display("FAIL reset_state got %h want %h", {strb, cause}, 12'h000); end
    mif.mem_rd_ready_i = 1'b0; rst_n = 1'b1;
    #1; vecs++;
    if ({strb, mif.mem_rd_addr_sel_o} !== {8'b1000_0000, MEM_RD_ADDR_SEL_PC})
      begin errs++; $display("FAIL reset_release got %b want %b", {strb, mif.mem_rd_addr_sel_o}, {8'b1000_0000, MEM_RD_ADDR_SEL_PC}); end
  endtask

  task automatic test_addi;
    ir = 32'h0050_0093; mif.mem_rd_ready_i = 1'b1;
    #1; vecs++;
    if (strb !== 8'b1010_0000) begin errs++; $display("FAIL addi_fetch got %b want %b", strb, 8'b1010_0000); end
    tick; vecs++;
    if (strb !== 8'b0001_1010) begin errs++; $display("FAIL addi_exec got %b want %b", strb, 8'b0001_1010); end
    vecs++;
    if ({npc, aop, a1, a2} !== {NEXT_PC_SEL_PC_PLUS_4, ALU_OP_ADD, ALU_IN1_SEL_RS1, ALU_IN2_SEL_IMM})
      begin errs++; $display("FAIL addi_dec got %h want %h", {npc, aop, a1, a2}, {NEXT_PC_SEL_PC_PLUS_4, ALU_OP_ADD, ALU_IN1_SEL_RS1, ALU_IN2_SEL_IMM}); end
    tick; mif.mem_rd_ready_i = 1'b0;
  endtask

  task automatic test_load;
    ir = 32'h0000_A103; mif.mem_rd_ready_i = 1'b1;
    #1; vecs++;
    if (strb !== 8'b1010_0000) begin errs++; $display("FAIL lw_fetch got %b want %b", strb, 8'b1010_0000); end
    tick; mif.mem_rd_ready_i = 1'b0;
    #1; vecs++;
    if (strb !== 8'h00) begin errs++; $display("FAIL lw_exec got %b want %b", strb, 8'h00); end
    tick;
    for (int i = 0; i < 3; i++) begin
      #1; vecs++;
      if ({strb, mif.mem_rd_addr_sel_o, mif.mem_rd_size_o} !== {8'b1000_0000, MEM_RD_ADDR_SEL_ALU_OUT, MEM_ACCESS_SIZE_WORD})
        begin errs++; $display("FAIL lw_wait%0d got %b want %b", i, {strb, mif.mem_rd_addr_sel_o, mif.mem_rd_size_o}, {8'b1000_0000, MEM_RD_ADDR_SEL_ALU_OUT, MEM_ACCESS_SIZE_WORD}); end
      tick;
    end
    mif.mem_rd_ready_i = 1'b1;
    #1; vecs++;
    if ({strb, mif.mem_rd_addr_sel_o, rfin} !== {8'b1001_1010, MEM_RD_ADDR_SEL_ALU_OUT, REGFILE_IN_SEL_MEM_RD})
      begin errs++; $display("FAIL lw_retire got %b want %b", {strb, mif.mem_rd_addr_sel_o, rfin}, {8'b1001_1010, MEM_RD_ADDR_SEL_ALU_OUT, REGFILE_IN_SEL_MEM_RD}); end
    tick; mif.mem_rd_ready_i = 1'b0;
    #1; vecs++;
    if ({strb, mif.mem_rd_addr_sel_o} !== {8'b1000_0000, MEM_RD_ADDR_SEL_PC})
      begin errs++; $display("FAIL lw_refetch got %b want %b", {strb, mif.mem_rd_addr_sel_o}, {8'b1000_0000, MEM_RD_ADDR_SEL_PC}); end
  endtask

  task automatic test_fetch_timeout;
    mif.mem_rd_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1; vecs++;
      if (strb !== 8'b1000_0000) begin errs++; $display("FAIL fto_wait%0d got %b want %b", i, strb, 8'b1000_0000); end
      tick;
    end
    #1; vecs++;
    if ({strb, cause, npc} !== {8'b0001_0001, CAUSE_FETCH_FAULT, NEXT_PC_SEL_TRAP_VECTOR})
      begin errs++; $display("FAIL fto_trap got %h want %h", {strb, cause, npc}, {8'b0001_0001, CAUSE_FETCH_FAULT, NEXT_PC_SEL_TRAP_VECTOR}); end
    tick; #1; vecs++;
    if (strb !== 8'b1000_0000) begin errs++; $display("FAIL fto_refetch got %b want %b", strb, 8'b1000_0000); end
  endtask

  task automatic test_illegal;
    ir = 32'hFFFF_FFFF; mif.mem_rd_ready_i = 1'b1;
    tick; mif.mem_rd_ready_i = 1'b0;
    #1; vecs++;
    if (strb !== 8'h00) begin errs++; $display("FAIL ill_exec got %b want %b", strb, 8'h00); end
    tick; vecs++;
    if ({strb, cause} !== {8'b0001_0001, CAUSE_ILLEGAL})
      begin errs++; $display("FAIL ill_trap got %h want %h", {strb, cause}, {8'b0001_0001, CAUSE_ILLEGAL}); end
    tick;
  endtask

  task automatic test_trap_disabled;
    rst_n = 1'b0;
    ir = 32'hFFFF_FFFF; mif2.mem_rd_ready_i = 1'b1; mif2.mem_wr_ready_i = 1'b0; rst2_n = 1'b1;
    #1; vecs++;
    if (strb2 !== 8'b1010_0000) begin errs++; $display("FAIL nt_fetch got %b want %b", strb2, 8'b1010_0000); end
    tick; mif2.mem_rd_ready_i = 1'b0; vecs++;
    if ({strb2, npc2} !== {8'b0001_0010, NEXT_PC_SEL_PC_PLUS_4})
      begin errs++; $display("FAIL nt_ill_retire got %b want %b", {strb2, npc2}, {8'b0001_0010, NEXT_PC_SEL_PC_PLUS_4}); end
    tick;
    for (int i = 0; i < 6; i++) begin
      #1; vecs++;
      if (strb2 !== 8'b1000_0000) begin errs++; $display("FAIL nt_no_timeout%0d got %b want %b", i, strb2, 8'b1000_0000); end
      tick;
    end
    rst2_n = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_system;
    logic [31:0] irs  [4] = '{32'h0000_0073, 32'h0010_0073, 32'h3001_10F3, 32'h0000_000F};
    logic [7:0]  exs  [4] = '{8'h00, 8'h00, 8'b0001_1110, 8'b0001_0010};
    logic        trp  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  cs   [4] = '{CAUSE_ECALL_M, CAUSE_BREAKPOINT, 4'd0, 4'd0};
    for (int k = 0; k < 4; k++) begin
      ir = irs[k]; mif.mem_rd_ready_i = 1'b1;
      #1; vecs++;
      if (strb !== 8'b1010_0000) begin errs++; $display("FAIL sys%0d_fetch got %b want %b", k, strb, 8'b1010_0000); end
      tick; mif.mem_rd_ready_i = 1'b0;
      #1; vecs++;
      if (strb !== exs[k]) begin errs++; $display("FAIL sys%0d_exec got %b want %b", k, strb, exs[k]); end
      tick;
      if (trp[k]) begin
        #1; vecs++;
        if ({strb, cause} !== {8'b0001_0001, cs[k]})
          begin errs++; $display("FAIL sys%0d_trap got %h want %h", k, {strb, cause}, {8'b0001_0001, cs[k]}); end
        tick;
      end
    end
  endtask

  task automatic test_store_expiry;
    ir = 32'h0011_2023; mif.mem_rd_ready_i = 1'b1;
    tick; mif.mem_rd_ready_i = 1'b0; tick;
    for (int i = 0; i < 15; i++) begin
      mif.mem_rd_ready_i = (i < 3);  // read ready during a store must be ignored
      #1; vecs++;
      if ({strb, mif.mem_wr_size_o} !== {8'b0100_0000, MEM_ACCESS_SIZE_WORD})
        begin errs++; $display("FAIL sw_wait%0d got %b want %b", i, {strb, mif.mem_wr_size_o}, {8'b0100_0000, MEM_ACCESS_SIZE_WORD}); end
      tick;
    end
    mif.mem_rd_ready_i = 1'b0; mif.mem_wr_ready_i = 1'b1;
    #1; vecs++;
    if (strb !== 8'b0101_0010) begin errs++; $display("FAIL sw_expiry_retire got %b want %b", strb, 8'b0101_0010); end
    tick; mif.mem_wr_ready_i = 1'b0;
    #1; vecs++;
    if (strb !== 8'b1000_0000) begin errs++; $display("FAIL sw_refetch got %b want %b", strb, 8'b1000_0000); end
    mif.mem_rd_ready_i = 1'b1;
    tick; mif.mem_rd_ready_i = 1'b0; tick;
    for (int i = 0; i < 16; i++) tick;
    #1; vecs++;
    if ({strb, cause} !== {8'b0001_0001, CAUSE_STORE_FAULT})
      begin errs++; $display("FAIL sw_timeout got %h want %h", {strb, cause}, {8'b0001_0001, CAUSE_STORE_FAULT}); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    ir = 32'h0000_A103; mif.mem_rd_ready_i = 1'b1;
    tick; mif.mem_rd_ready_i = 1'b0; tick; tick; tick;
    rst_n = 1'b0;
    #1; vecs++;
    if (strb !== 8'h00) begin errs++; $display("FAIL rst_mid_drop got %b want %b", strb, 8'h00); end
    tick; vecs++;
    if ({strb, cause} !== 12'h000) begin errs++; $display("FAIL rst_mid_hold got %h want %h", {strb, cause}, 12'h000); end
    rst_n = 1'b1;
    #1; vecs++;
    if ({strb, mif.mem_rd_addr_sel_o} !== {8'b1000_0000, MEM_RD_ADDR_SEL_PC})
      begin errs++; $display("FAIL rst_mid_fetch got %b want %b", {strb, mif.mem_rd_addr_sel_o}, {8'b1000_0000, MEM_RD_ADDR_SEL_PC}); end
  endtask

  initial begin
    mif2.mem_rd_ready_i = 1'b0; mif2.mem_wr_ready_i = 1'b0;
    test_reset;
    test_addi;
    test_load;
    test_fetch_timeout;
    test_illegal;
    test_trap_disabled;
    test_system;
    test_store_expiry;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d vectors", vecs);
    $fatal(1, "timeout");
  end
endmodule
